// File: rtl/mem_port_arbiter.sv
// Round-robin burst arbiter sharing one memory port between a read master and a write master.
// Whole bursts are granted; addresses increment per beat and each burst ends with a one-cycle GAP.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 5,
   parameter int ADDR_STEP = 4
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [LEN_W-1:0]  rd_len,
   output logic              rd_gnt,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_done,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LEN_W-1:0]  wr_len,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              wr_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read_flag,
   output logic              mem_write_flag,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        o_owner,
   output logic              o_busy
);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, GAP} state_t;

   localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  beats_q;
   logic [LEN_W-1:0]  beat_cnt;
   logic [1:0]        owner_q;
   logic              last_wr;
   logic              last_beat;

   assign last_beat = (beat_cnt + LEN_ONE) == beats_q;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state    <= IDLE;
         addr_q   <= '0;
         beats_q  <= '0;
         beat_cnt <= '0;
         owner_q  <= '0;
         last_wr  <= 1'b1;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_done  <= 1'b0;
         wr_done  <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         rd_done  <= 1'b0;
         wr_done  <= 1'b0;
         case (state)
            IDLE: begin
               // read wins a tie only when the write side was served last
               if (rd_req && (!wr_req || last_wr)) begin
                  state    <= RD_BURST;
                  owner_q  <= 2'b01;
                  last_wr  <= 1'b0;
                  addr_q   <= rd_addr;
                  beats_q  <= (rd_len == '0) ? LEN_ONE : rd_len;
                  beat_cnt <= '0;
               end else if (wr_req) begin
                  state    <= WR_BURST;
                  owner_q  <= 2'b10;
                  last_wr  <= 1'b1;
                  addr_q   <= wr_addr;
                  beats_q  <= (wr_len == '0) ? LEN_ONE : wr_len;
                  beat_cnt <= '0;
               end
            end
            RD_BURST: begin
               rd_data  <= mem_rdata;
               rd_valid <= 1'b1;
               addr_q   <= addr_q + STEP;
               beat_cnt <= beat_cnt + LEN_ONE;
               if (last_beat) begin
                  state   <= GAP;
                  rd_done <= 1'b1;
               end
            end
            WR_BURST: begin
               addr_q   <= addr_q + STEP;
               beat_cnt <= beat_cnt + LEN_ONE;
               if (last_beat) begin
                  state   <= GAP;
                  wr_done <= 1'b1;
               end
            end
            GAP: begin
               state   <= IDLE;
               owner_q <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_read_flag  = (state == RD_BURST);
   assign mem_write_flag = (state == WR_BURST);
   assign wr_ready       = mem_write_flag;
   assign mem_addr       = (mem_read_flag || mem_write_flag) ? addr_q : '0;
   assign mem_wdata      = mem_write_flag ? wr_data : '0;
   assign o_owner        = owner_q;
   assign rd_gnt         = owner_q[0];
   assign o_busy         = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle expectations with a small word memory model.
module tb_mem_port_arbiter;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        rd_req, wr_req;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic [4:0]  rd_len, wr_len;
   logic        rd_gnt, rd_valid, rd_done, wr_ready, wr_done;
   logic        mem_read_flag, mem_write_flag, o_busy;
   logic [31:0] rd_data, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  o_owner;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0]  mem_arr [256];
   logic [255:0] mem_wr = '0;

   always #5 HCLK = ~HCLK;

   // unwritten words read back as addr ^ 0xA5A5
   assign mem_rdata = mem_wr[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]] : (mem_addr ^ 32'h0000A5A5);

   always @(posedge HCLK) begin
      if (mem_write_flag) begin
         mem_arr[mem_addr[9:2]] <= mem_wdata;
         mem_wr[mem_addr[9:2]]  <= 1'b1;
      end
   end

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(5), .ADDR_STEP(4)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
      .wr_ready(wr_ready), .wr_done(wr_done),
      .mem_addr(mem_addr), .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .o_owner(o_owner), .o_busy(o_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_cyc(input string tag, input int busy, input int owner, input int rf,
                          input int wf, input logic [31:0] addr, input int rv,
                          input logic [31:0] rdata, input int rd, input int wd);
      check({tag, "_busy"},   32'(o_busy), busy);
      check({tag, "_owner"},  32'(o_owner), owner);
      check({tag, "_rdgnt"},  32'(rd_gnt), (owner == 1) ? 1 : 0);
      check({tag, "_rflag"},  32'(mem_read_flag), rf);
      check({tag, "_wflag"},  32'(mem_write_flag), wf);
      check({tag, "_wready"}, 32'(wr_ready), wf);
      check({tag, "_addr"},   mem_addr, addr);
      check({tag, "_rvalid"}, 32'(rd_valid), rv);
      if (rv != 0) check({tag, "_rdata"}, rd_data, rdata);
      check({tag, "_rdone"},  32'(rd_done), rd);
      check({tag, "_wdone"},  32'(wr_done), wd);
   endtask

   task automatic exp_idle(input string tag);
      exp_cyc(tag, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
   endtask

   task automatic step();
      @(negedge HCLK);
   endtask

   initial begin
      HRESET = 1'b1;
      rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      rd_len = '0; wr_len = '0;
      step();
      step();
      exp_idle("rst");
      check("rst_rdata", rd_data, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);

      // 1: 4-beat read from 0x100
      HRESET = 1'b0;
      rd_req = 1'b1; rd_addr = 32'h100; rd_len = 5'd4;
      step();
      for (int b = 0; b < 4; b++) begin
         rd_req = 1'b0;
         exp_cyc("t1_beat", 1, 1, 1, 0, 32'h100 + 32'(4*b), (b > 0) ? 1 : 0,
                 (32'h100 + 32'(4*(b-1))) ^ 32'hA5A5, 0, 0);
         step();
      end
      exp_cyc("t1_gap", 1, 1, 0, 0, 32'h0, 1, 32'h10C ^ 32'hA5A5, 1, 0);
      step();
      exp_idle("t1_idle");

      // 2: 2-beat write to 0x200, then read it back
      wr_req = 1'b1; wr_addr = 32'h200; wr_len = 5'd2;
      step();
      for (int b = 0; b < 2; b++) begin
         wr_req = 1'b0;
         wr_data = (b == 0) ? 32'h11 : 32'h22;
         #1;
         exp_cyc("t2_beat", 1, 2, 0, 1, 32'h200 + 32'(4*b), 0, 32'h0, 0, 0);
         check("t2_wdata", mem_wdata, (b == 0) ? 32'h11 : 32'h22);
         step();
      end
      exp_cyc("t2_gap", 1, 2, 0, 0, 32'h0, 0, 32'h0, 0, 1);
      check("t2_gap_wdata", mem_wdata, 32'h0);
      step();
      exp_idle("t2_idle");
      rd_req = 1'b1; rd_addr = 32'h200; rd_len = 5'd2;
      step();
      for (int b = 0; b < 2; b++) begin
         rd_req = 1'b0;
         exp_cyc("t2_rb", 1, 1, 1, 0, 32'h200 + 32'(4*b), b, 32'h11, 0, 0);
         step();
      end
      exp_cyc("t2_rbgap", 1, 1, 0, 0, 32'h0, 1, 32'h22, 1, 0);
      step();
      exp_idle("t2_rbidle");

      // 3: simultaneous requests out of reset, round-robin alternation
      HRESET = 1'b1;
      step();
      HRESET = 1'b0;
      rd_req = 1'b1; rd_addr = 32'h40; rd_len = 5'd1;
      wr_req = 1'b1; wr_addr = 32'h80; wr_len = 5'd1; wr_data = 32'h33;
      step();
      rd_req = 1'b0;
      exp_cyc("t3_rd1", 1, 1, 1, 0, 32'h40, 0, 32'h0, 0, 0);
      step();
      exp_cyc("t3_rgap1", 1, 1, 0, 0, 32'h0, 1, 32'h40 ^ 32'hA5A5, 1, 0);
      step();
      exp_idle("t3_idle1");
      step();
      wr_req = 1'b0;
      #1;
      exp_cyc("t3_wr1", 1, 2, 0, 1, 32'h80, 0, 32'h0, 0, 0);
      check("t3_wdata", mem_wdata, 32'h33);
      step();
      exp_cyc("t3_wgap1", 1, 2, 0, 0, 32'h0, 0, 32'h0, 0, 1);
      step();
      exp_idle("t3_idle2");
      rd_req = 1'b1; rd_addr = 32'h44;
      wr_req = 1'b1; wr_addr = 32'h84;
      step();
      rd_req = 1'b0;
      exp_cyc("t3_rd2", 1, 1, 1, 0, 32'h44, 0, 32'h0, 0, 0);
      step();
      exp_cyc("t3_rgap2", 1, 1, 0, 0, 32'h0, 1, 32'h44 ^ 32'hA5A5, 1, 0);
      step();
      exp_idle("t3_idle3");
      rd_req = 1'b1;
      step();
      wr_req = 1'b0;
      exp_cyc("t3_wr2", 1, 2, 0, 1, 32'h84, 0, 32'h0, 0, 0);
      step();
      exp_cyc("t3_wgap2", 1, 2, 0, 0, 32'h0, 0, 32'h0, 0, 1);
      step();
      exp_idle("t3_idle4");

      // 4: rd_len=0 acts as one beat (rd_req still pending), then a 31-beat write
      rd_addr = 32'h48; rd_len = 5'd0;
      step();
      rd_req = 1'b0;
      exp_cyc("t4_rd", 1, 1, 1, 0, 32'h48, 0, 32'h0, 0, 0);
      step();
      exp_cyc("t4_rgap", 1, 1, 0, 0, 32'h0, 1, 32'h48 ^ 32'hA5A5, 1, 0);
      step();
      exp_idle("t4_idle1");
      wr_req = 1'b1; wr_addr = 32'h300; wr_len = 5'd31;
      step();
      for (int b = 0; b < 31; b++) begin
         wr_req = 1'b0;
         wr_data = 32'h1000 + 32'(b);
         #1;
         exp_cyc("t4_wbeat", 1, 2, 0, 1, 32'h300 + 32'(4*b), 0, 32'h0, 0, 0);
         check("t4_wdata", mem_wdata, 32'h1000 + 32'(b));
         step();
      end
      exp_cyc("t4_wgap", 1, 2, 0, 0, 32'h0, 0, 32'h0, 0, 1);
      step();
      exp_idle("t4_idle2");

      // 5: address wrap at the top of the space
      rd_req = 1'b1; rd_addr = 32'hFFFF_FFFC; rd_len = 5'd2;
      step();
      rd_req = 1'b0;
      exp_cyc("t5_b0", 1, 1, 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 0);
      step();
      exp_cyc("t5_b1", 1, 1, 1, 0, 32'h0, 1, 32'hFFFF_5A59, 0, 0);
      step();
      exp_cyc("t5_gap", 1, 1, 0, 0, 32'h0, 1, 32'h0000_A5A5, 1, 0);
      step();
      exp_idle("t5_idle");

      // 6: reset on the 2nd beat of a 4-beat write, then a normal read
      wr_req = 1'b1; wr_addr = 32'h280; wr_len = 5'd4;
      step();
      wr_req = 1'b0; wr_data = 32'hA1;
      #1;
      exp_cyc("t6_b0", 1, 2, 0, 1, 32'h280, 0, 32'h0, 0, 0);
      step();
      wr_data = 32'hA2;
      #1;
      exp_cyc("t6_b1", 1, 2, 0, 1, 32'h284, 0, 32'h0, 0, 0);
      HRESET = 1'b1;
      step();
      exp_idle("t6_rst");
      check("t6_rst_rdata", rd_data, 32'h0);
      check("t6_rst_wdata", mem_wdata, 32'h0);
      HRESET = 1'b0;
      rd_req = 1'b1; rd_addr = 32'h140; rd_len = 5'd1;
      step();
      rd_req = 1'b0;
      exp_cyc("t6_rd", 1, 1, 1, 0, 32'h140, 0, 32'h0, 0, 0);
      step();
      exp_cyc("t6_rgap", 1, 1, 0, 0, 32'h0, 1, 32'h0000_A4E5, 1, 0);
      step();
      exp_idle("t6_idle1");
      step();
      exp_idle("t6_idle2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
